interrupt_ack_sequencer: RTL and testbench

- Consumer end of the priority resolver's `interrupt` output in the 8259-compatible PIC.
- Raises INT and runs the 8086-mode two-pulse INTA handshake.
- Owns the in-service register (ISR), IRR clear pulses, the vector byte, EOI handling and the priority rotation value.
- Feeds `in_service_register`, `priority_rotate` and `freeze` back to the resolver.

---
 rtl/interrupt_ack_sequencer_if.sv | 34 +++
 rtl/interrupt_ack_sequencer.sv | 151 +++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_ack_sequencer_if.sv
// rtl/interrupt_ack_sequencer_if.sv - CPU/resolver/OCW signal bundle for the interrupt acknowledge sequencer
interface interrupt_ack_sequencer_if;
    logic [7:0] interrupt;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       rotate_aeoi;
    logic       eoi_valid;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic       set_priority;
    logic [2:0] eoi_level;
    logic       int_out;
    logic       freeze;
    logic [7:0] in_service_register;
    logic [2:0] priority_rotate;
    logic [7:0] clear_irr;
    logic [7:0] data_out;
    logic       data_out_en;

    modport master (
        output interrupt, inta_n, vector_base, auto_eoi, rotate_aeoi,
               eoi_valid, eoi_specific, eoi_rotate, set_priority, eoi_level,
        input  int_out, freeze, in_service_register, priority_rotate,
               clear_irr, data_out, data_out_en
    );

    modport slave (
        input  interrupt, inta_n, vector_base, auto_eoi, rotate_aeoi,
               eoi_valid, eoi_specific, eoi_rotate, set_priority, eoi_level,
        output int_out, freeze, in_service_register, priority_rotate,
               clear_irr, data_out, data_out_en
    );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - INT/INTA handshake, in-service register, EOI and priority rotation
module interrupt_ack_sequencer #(
    parameter int NUM_IRQ = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    interrupt_ack_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    state_t               state_q;
    logic                 inta_prev_q;
    logic [2:0]           level_q;
    logic                 spurious_q;
    logic                 int_out_q;
    logic                 freeze_q;
    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [2:0]           prio_q, prio_d;
    logic [NUM_IRQ-1:0]   clear_irr_q;
    logic [7:0]           data_out_q;
    logic                 data_out_en_q;

    logic                 fall, rise, irq_any;
    logic [2:0]           irq_level;
    logic                 ns_found;
    logic [2:0]           ns_level, ns_probe;
    logic                 take_ack, ack_real, finish, aeoi_hit;
    logic [NUM_IRQ-1:0]   set_mask, eoi_mask, aeoi_mask;

    assign fall    = inta_prev_q & ~bus.inta_n;
    assign rise    = ~inta_prev_q & bus.inta_n;
    assign irq_any = |bus.interrupt;

    assign take_ack = (state_q == IDLE) && fall;
    assign ack_real = take_ack && irq_any;
    assign finish   = (state_q == ACK2) && rise;
    assign aeoi_hit = finish && bus.auto_eoi && !spurious_q;

    // Encode the resolver request; the lowest set bit wins if it is ever not one-hot, 7 when empty
    always_comb begin
        irq_level = 3'd7;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (bus.interrupt[i]) irq_level = 3'(i);
        end
    end

    // Non-specific EOI target: first in-service bit walking up from the highest-priority level
    always_comb begin
        ns_found = 1'b0;
        ns_level = prio_q;
        ns_probe = prio_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ns_probe = prio_q + 3'(i);
            if (!ns_found && isr_q[ns_probe]) begin
                ns_found = 1'b1;
                ns_level = ns_probe;
            end
        end
    end

    // Next ISR and rotation: clears (EOI and AEOI) apply before the acknowledge set; external EOI rotation overrides AEOI rotation
    always_comb begin
        set_mask  = '0;
        eoi_mask  = '0;
        aeoi_mask = '0;
        prio_d    = prio_q;
        if (aeoi_hit) begin
            aeoi_mask = ONE << level_q;
            if (bus.rotate_aeoi) prio_d = level_q + 3'd1;
        end
        if (bus.eoi_valid) begin
            if (bus.set_priority) begin
                prio_d = bus.eoi_level + 3'd1;
            end else if (bus.eoi_specific) begin
                eoi_mask = ONE << bus.eoi_level;
                if (bus.eoi_rotate) prio_d = bus.eoi_level + 3'd1;
            end else if (ns_found) begin
                eoi_mask = ONE << ns_level;
                if (bus.eoi_rotate) prio_d = ns_level + 3'd1;
            end
        end
        if (ack_real) set_mask = ONE << irq_level;
        isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;
    end

    // Acknowledge state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            inta_prev_q   <= 1'b1;
            level_q       <= 3'd0;
            spurious_q    <= 1'b0;
            int_out_q     <= 1'b0;
            freeze_q      <= 1'b0;
            isr_q         <= '0;
            prio_q        <= 3'd0;
            clear_irr_q   <= '0;
            data_out_q    <= 8'h00;
            data_out_en_q <= 1'b0;
        end else begin
            inta_prev_q <= bus.inta_n;
            clear_irr_q <= '0;
            isr_q       <= isr_d;
            prio_q      <= prio_d;
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q    <= ACK1;
                        int_out_q  <= 1'b0;
                        freeze_q   <= 1'b1;
                        level_q    <= irq_any ? irq_level : 3'd7;
                        spurious_q <= !irq_any;
                        if (irq_any) clear_irr_q <= bus.interrupt;
                    end else begin
                        int_out_q <= irq_any;
                    end
                end
                ACK1: begin
                    if (rise) state_q <= GAP;
                end
                GAP: begin
                    if (fall) begin
                        state_q       <= ACK2;
                        data_out_q    <= {bus.vector_base, level_q};
                        data_out_en_q <= 1'b1;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        state_q       <= IDLE;
                        data_out_en_q <= 1'b0;
                        freeze_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.int_out             = int_out_q;
    assign bus.freeze              = freeze_q;
    assign bus.in_service_register = isr_q;
    assign bus.priority_rotate     = prio_q;
    assign bus.clear_irr           = clear_irr_q;
    assign bus.data_out            = data_out_q;
    assign bus.data_out_en         = data_out_en_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// tb/tb_interrupt_ack_sequencer.sv - directed self-checking bench for interrupt_ack_sequencer
module tb_interrupt_ack_sequencer;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    interrupt_ack_sequencer_if bus ();

    interrupt_ack_sequencer #(.NUM_IRQ(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inta(input logic v);
        bus.inta_n = v;
        tick();
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic full_ack(input logic [7:0] irq);
        bus.interrupt = irq;
        tick();
        inta(1'b0);
        bus.interrupt = 8'h00;
        inta(1'b1);
        inta(1'b0);
        inta(1'b1);
    endtask

    task automatic eoi(input logic spec, input logic rot, input logic setp, input logic [2:0] lvl);
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = spec;
        bus.eoi_rotate   = rot;
        bus.set_priority = setp;
        bus.eoi_level    = lvl;
        tick();
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_rotate   = 1'b0;
        bus.set_priority = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.interrupt    = 8'h00;
        bus.inta_n       = 1'b1;
        bus.vector_base  = 5'h10;
        bus.auto_eoi     = 1'b0;
        bus.rotate_aeoi  = 1'b0;
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_rotate   = 1'b0;
        bus.set_priority = 1'b0;
        bus.eoi_level    = 3'd0;
        tick();
        tick();
        chk1("rst_int_out", bus.int_out, 1'b0);
        chk1("rst_freeze", bus.freeze, 1'b0);
        chk8("rst_isr", bus.in_service_register, 8'h00);
        chk8("rst_prio", 8'(bus.priority_rotate), 8'h00);
        chk8("rst_clear_irr", bus.clear_irr, 8'h00);
        chk1("rst_den", bus.data_out_en, 1'b0);
        chk8("rst_data", bus.data_out, 8'h00);

        // int_out follows the request one cycle later
        reset = 1'b0;
        bus.interrupt = 8'h04;
        tick();
        chk1("int_rise", bus.int_out, 1'b1);
        chk8("int_isr", bus.in_service_register, 8'h00);
        chk1("int_den", bus.data_out_en, 1'b0);

        // normal EOI-mode acknowledge of level 2
        inta(1'b0);
        chk8("ack1_clear_irr", bus.clear_irr, 8'h04);
        chk8("ack1_isr", bus.in_service_register, 8'h04);
        chk1("ack1_freeze", bus.freeze, 1'b1);
        chk1("ack1_int_out", bus.int_out, 1'b0);
        bus.interrupt = 8'h00;
        tick();
        chk8("ack1_clear_pulse", bus.clear_irr, 8'h00);
        inta(1'b1);
        chk1("gap_freeze", bus.freeze, 1'b1);
        chk1("gap_den", bus.data_out_en, 1'b0);
        inta(1'b0);
        chk8("ack2_data", bus.data_out, 8'h82);
        chk1("ack2_den", bus.data_out_en, 1'b1);
        inta(1'b1);
        chk1("end_den", bus.data_out_en, 1'b0);
        chk1("end_freeze", bus.freeze, 1'b0);
        chk8("end_isr", bus.in_service_register, 8'h04);

        eoi(1'b1, 1'b0, 1'b0, 3'd2);
        chk8("spec_eoi_isr", bus.in_service_register, 8'h00);
        chk8("spec_eoi_prio", 8'(bus.priority_rotate), 8'h00);

        // automatic EOI with rotation
        bus.auto_eoi    = 1'b1;
        bus.rotate_aeoi = 1'b1;
        bus.interrupt   = 8'h04;
        tick();
        inta(1'b0);
        chk8("aeoi_isr_set", bus.in_service_register, 8'h04);
        bus.interrupt = 8'h00;
        inta(1'b1);
        inta(1'b0);
        chk8("aeoi_data", bus.data_out, 8'h82);
        inta(1'b1);
        chk8("aeoi_isr_clr", bus.in_service_register, 8'h00);
        chk8("aeoi_prio", 8'(bus.priority_rotate), 8'h03);
        chk1("aeoi_freeze", bus.freeze, 1'b0);
        bus.auto_eoi    = 1'b0;
        bus.rotate_aeoi = 1'b0;

        // build ISR = 8'h81
        full_ack(8'h80);
        full_ack(8'h01);
        chk8("build_isr", bus.in_service_register, 8'h81);

        // spurious acknowledge: AEOI armed but must not touch ISR or rotation
        bus.auto_eoi    = 1'b1;
        bus.rotate_aeoi = 1'b1;
        inta(1'b0);
        chk8("spur_clear_irr", bus.clear_irr, 8'h00);
        chk8("spur_isr_ack1", bus.in_service_register, 8'h81);
        chk1("spur_freeze", bus.freeze, 1'b1);
        inta(1'b1);
        inta(1'b0);
        chk8("spur_data", bus.data_out, 8'h87);
        inta(1'b1);
        chk8("spur_isr_end", bus.in_service_register, 8'h81);
        chk8("spur_prio", 8'(bus.priority_rotate), 8'h03);
        bus.auto_eoi    = 1'b0;
        bus.rotate_aeoi = 1'b0;

        // set priority so level 7 is highest, then rotating non-specific EOI
        eoi(1'b0, 1'b0, 1'b1, 3'd6);
        chk8("setp_prio", 8'(bus.priority_rotate), 8'h07);
        chk8("setp_isr", bus.in_service_register, 8'h81);
        eoi(1'b0, 1'b1, 1'b0, 3'd0);
        chk8("ns_rot_isr", bus.in_service_register, 8'h01);
        chk8("ns_rot_prio", 8'(bus.priority_rotate), 8'h00);

        // non-specific from level 0, then specific level 7, then empty non-specific
        full_ack(8'h80);
        chk8("rebuild_isr", bus.in_service_register, 8'h81);
        eoi(1'b0, 1'b0, 1'b0, 3'd0);
        chk8("ns_isr", bus.in_service_register, 8'h80);
        eoi(1'b1, 1'b0, 1'b0, 3'd7);
        chk8("spec7_isr", bus.in_service_register, 8'h00);
        eoi(1'b0, 1'b1, 1'b0, 3'd0);
        chk8("ns_empty_isr", bus.in_service_register, 8'h00);
        chk8("ns_empty_prio", 8'(bus.priority_rotate), 8'h00);

        // EOI clear and acknowledge set on the same bit in the same cycle
        bus.interrupt = 8'h04;
        tick();
        bus.inta_n       = 1'b0;
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = 1'b1;
        bus.eoi_level    = 3'd2;
        tick();
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
        chk8("same_bit_isr", bus.in_service_register, 8'h04);
        bus.interrupt = 8'h00;
        inta(1'b1);
        chk1("pre_rst_freeze", bus.freeze, 1'b1);

        // reset while in GAP
        reset = 1'b1;
        tick();
        chk1("midrst_freeze", bus.freeze, 1'b0);
        chk8("midrst_isr", bus.in_service_register, 8'h00);
        chk1("midrst_den", bus.data_out_en, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        chk1("post_rst_freeze", bus.freeze, 1'b0);
        chk1("post_rst_int", bus.int_out, 1'b0);

        // a fresh acknowledge starts from IDLE after the reset
        bus.interrupt = 8'h08;
        tick();
        inta(1'b0);
        chk8("fresh_clear_irr", bus.clear_irr, 8'h08);
        bus.interrupt = 8'h00;
        inta(1'b1);
        inta(1'b0);
        chk8("fresh_data", bus.data_out, 8'h83);
        chk1("fresh_den", bus.data_out_en, 1'b1);
        inta(1'b1);
        chk8("fresh_isr", bus.in_service_register, 8'h08);
        chk1("fresh_freeze", bus.freeze, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
